// File: rtl/dp_vec_streamer_if.sv
// Output stream of the operand streamer: one NUM_CH-wide element tuple per
// transfer, tagged with its run index and vector/run end markers.
interface dp_vec_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CH     = 2
);
  // A transfer completes on a rising clk edge where out_valid and out_ready are
  // both 1. Once out_valid is raised, it and all payload fields (out_data,
  // out_idx, out_vec_last, out_last) hold until that edge. out_valid never
  // depends combinationally on out_ready.
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH:0]          out_idx;
  logic                         out_vec_last;
  logic                         out_last;

  modport master (
    output out_valid, out_data, out_idx, out_vec_last, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_idx, out_vec_last, out_last,
    output out_ready
  );
endinterface

// File: rtl/dp_vec_streamer.sv
// Multi-channel operand streamer: credit-limited lock-step reads from NUM_CH
// memories, latency absorbed by a small FIFO, valid/ready output with markers.
module dp_vec_streamer #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_CH       = 2,
  parameter int VECTOR_WIDTH = 4,
  parameter int RD_LATENCY   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH:0]          length,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic [1:0]                   dbg_state,
  dp_vec_streamer_if.master            out_if
);
  localparam int DW         = NUM_CH * DATA_WIDTH;
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int VW         = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;

  localparam logic [PW-1:0]       LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]         DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [VW-1:0]       VEC_END  = VW'(VECTOR_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_L    = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_len, r_issue_cnt, r_out_idx;
  logic [VW-1:0]         r_vec_cnt;
  logic [RD_LATENCY-1:0] r_sr, w_sr_next;
  logic [CW-1:0]         r_in_flight, r_fifo_cnt;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [DW-1:0]         r_mem [2**PW];

  logic w_start_acc, w_flush, w_credit_ok, w_issue, w_last_issue;
  logic w_push, w_pop, w_out_valid, w_out_last;

  assign w_start_acc  = start && !abort && (r_state == S_IDLE);
  assign w_flush      = abort && (r_state != S_IDLE);
  // Credits cover both reads still in the memory pipe and data parked in the
  // FIFO, so every returning word always has a free slot.
  assign w_credit_ok  = ({1'b0, r_in_flight} + {1'b0, r_fifo_cnt}) < DEPTH_C;
  assign w_issue      = (r_state == S_RUN) && w_credit_ok;
  assign w_last_issue = w_issue && (r_issue_cnt == r_len - ONE_L);
  assign w_push       = r_sr[RD_LATENCY-1];
  assign w_out_valid  = (r_fifo_cnt != '0);
  assign w_pop        = w_out_valid && out_if.out_ready;
  assign w_out_last   = w_out_valid && (r_out_idx == r_len - ONE_L);

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) w_next = (length == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last_issue) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_pop && w_out_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
    end else if (w_start_acc) begin
      r_base      <= base_addr;
      r_len       <= length;
      r_issue_cnt <= '0;
    end else if (w_issue) begin
      r_issue_cnt <= r_issue_cnt + ONE_L;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_idx <= '0;
      r_vec_cnt <= '0;
    end else if (w_start_acc) begin
      r_out_idx <= '0;
      r_vec_cnt <= '0;
    end else if (w_pop) begin
      r_out_idx <= r_out_idx + ONE_L;
      r_vec_cnt <= (r_vec_cnt == VEC_END) ? '0 : r_vec_cnt + VW'(1);
    end
  end

  always_comb begin
    w_sr_next    = '0;
    w_sr_next[0] = w_issue;
    for (int i = 1; i < RD_LATENCY; i++) w_sr_next[i] = r_sr[i-1];
  end

  // Clearing the pipe on abort drops any words that are still on their way back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr        <= '0;
      r_in_flight <= '0;
    end else if (w_flush) begin
      r_sr        <= '0;
      r_in_flight <= '0;
    end else begin
      r_sr        <= w_sr_next;
      r_in_flight <= r_in_flight + CW'(w_issue) - CW'(w_push);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**PW; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= rd_data;
    end
  end

  assign rd_en     = w_issue;
  assign rd_addr   = r_base + r_issue_cnt[ADDR_WIDTH-1:0];
  assign dbg_state = r_state;

  assign out_if.out_valid    = w_out_valid;
  assign out_if.out_data     = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_if.out_idx      = r_out_idx;
  assign out_if.out_last     = w_out_last;
  assign out_if.out_vec_last = w_out_last || (w_out_valid && (r_vec_cnt == VEC_END));
endmodule

// File: tb/tb_dp_vec_streamer.sv
// Bench for dp_vec_streamer: two instances (read latency 1 and 3) share one
// stimulus stream; results of the selected one are scored against a run model.
`timescale 1ns/1ps
module tb_dp_vec_streamer;
  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int NCH = 2;
  localparam int VW  = 4;
  localparam int LA  = 1;
  localparam int LB  = 3;
  localparam int TW  = NCH*DW + AW + 1 + 2;
  localparam int SW  = 4 + AW + 1 + NCH*DW + AW + 1 + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b1;
  logic          sel = 1'b0;

  logic busy_a, done_a, rd_en_a, busy_b, done_b, rd_en_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [NCH*DW-1:0] rd_data_a, rd_data_b;
  logic [1:0] dbg_a, dbg_b;

  dp_vec_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH)) if_a ();
  dp_vec_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH)) if_b ();
  assign if_a.out_ready = out_ready;
  assign if_b.out_ready = out_ready;

  dp_vec_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH),
                    .VECTOR_WIDTH(VW), .RD_LATENCY(LA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base), .length(len),
    .abort(abort), .busy(busy_a), .done(done_a), .rd_en(rd_en_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .dbg_state(dbg_a), .out_if(if_a.master)
  );

  dp_vec_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH),
                    .VECTOR_WIDTH(VW), .RD_LATENCY(LB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base), .length(len),
    .abort(abort), .busy(busy_b), .done(done_b), .rd_en(rd_en_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .dbg_state(dbg_b), .out_if(if_b.master)
  );

  // ---------------- memory models: mem_k[a] = a + 16k ----------------
  logic [AW-1:0]     pa_a [LA];
  logic              pv_a [LA];
  logic [AW-1:0]     pa_b [LB];
  logic              pv_b [LB];
  logic [NCH*DW-1:0] junk;

  function automatic logic [NCH*DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] c0, c1;
    c0 = DW'(a);
    c1 = DW'(a) + DW'(16);
    return {c1, c0};
  endfunction

  always @(posedge clk) begin
    junk     <= NCH*DW'($urandom);
    pa_a[0]  <= rd_addr_a;
    pv_a[0]  <= rd_en_a;
    pa_b[0]  <= rd_addr_b;
    pv_b[0]  <= rd_en_b;
    for (int i = 1; i < LB; i++) begin
      pa_b[i] <= pa_b[i-1];
      pv_b[i] <= pv_b[i-1];
    end
  end
  // Outside a valid return slot the bus carries garbage.
  assign rd_data_a = pv_a[LA-1] ? mem_word(pa_a[LA-1]) : junk;
  assign rd_data_b = pv_b[LB-1] ? mem_word(pa_b[LB-1]) : junk;

  // ---------------- selected-DUT view ----------------
  logic m_busy, m_done, m_rd_en, m_valid;
  logic [AW-1:0] m_rd_addr;
  logic [TW-1:0] m_tuple;
  assign m_busy    = sel ? busy_b : busy_a;
  assign m_done    = sel ? done_b : done_a;
  assign m_rd_en   = sel ? rd_en_b : rd_en_a;
  assign m_rd_addr = sel ? rd_addr_b : rd_addr_a;
  assign m_valid   = sel ? if_b.out_valid : if_a.out_valid;
  assign m_tuple   = sel ? {if_b.out_data, if_b.out_idx, if_b.out_vec_last, if_b.out_last}
                         : {if_a.out_data, if_a.out_idx, if_a.out_vec_last, if_a.out_last};

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] obs_q[$];
  logic [AW-1:0] addr_q[$];
  int first_valid_rel, last_hs_rel, done_rel, done_cnt, busy_cnt;
  int max_out, stall_bad, post_abort_bad;

  // Reference run: element i comes from address (base+i) mod 32.
  function automatic void build_exp(input int b, input int n);
    int a;
    logic lst, vl;
    logic [NCH*DW-1:0] d;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a   = (b + i) % (1 << AW);
      d   = {DW'(a + 16), DW'(a)};
      lst = (i == n - 1);
      vl  = lst || ((i % VW) == VW - 1);
      exp_q.push_back({d, (AW+1)'(i), vl, lst});
    end
  endfunction

  // ---------------- driver / monitor ----------------
  // rmode: 0 ready always, 1 ready pattern 1-0-0-1, 2 random ready.
  task automatic run(input logic [AW-1:0] b, input logic [AW:0] n, input int rmode,
                     input int abort_at, input bit mid_start, input int budget);
    int issued, hs, post, outst;
    logic hold_v;
    logic [TW-1:0] hold_t;
    obs_q.delete();
    addr_q.delete();
    first_valid_rel = -1; last_hs_rel = -1; done_rel = -1; done_cnt = 0;
    busy_cnt = 0; max_out = 0; stall_bad = 0; post_abort_bad = 0;
    issued = 0; hs = 0; post = -1; hold_v = 1'b0; hold_t = '0;
    @(negedge clk);
    start = 1'b1; base = b; len = n; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; base = AW'($urandom); len = (AW+1)'($urandom_range(1, 32));
    for (int rel = 1; rel <= budget; rel++) begin
      if (rel > 1) @(negedge clk);
      abort = 1'b0;
      start = mid_start && (rel == 4);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((rel % 4) == 1) || ((rel % 4) == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (post < 0) begin
        if (m_busy) busy_cnt++;
        if (m_rd_en) addr_q.push_back(m_rd_addr);
        outst = issued + int'(m_rd_en) - hs;
        if (outst > max_out) max_out = outst;
        if (m_rd_en) issued++;
        if (m_done) begin
          done_cnt++;
          if (done_rel < 0) done_rel = rel;
        end
        if (hold_v && !(m_valid && m_tuple == hold_t)) stall_bad++;
        hold_v = m_valid && !out_ready;
        hold_t = m_tuple;
        if (m_valid && first_valid_rel < 0) first_valid_rel = rel;
        if (m_valid && out_ready) begin
          obs_q.push_back(m_tuple);
          hs++;
          last_hs_rel = rel;
          if (abort_at > 0 && hs == abort_at) begin
            abort = 1'b1;
            post = 0;
          end
        end
        if (done_rel > 0 && rel >= done_rel + 2) break;
      end else begin
        post++;
        if (m_valid || m_done || m_rd_en || m_busy) post_abort_bad++;
        if (post == 8) break;
      end
    end
    @(negedge clk);
    abort = 1'b0; start = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 80 && (busy_a || busy_b); k++) @(negedge clk);
    n_checks++;
    if (busy_a || busy_b) begin
      n_fail++;
      $display("FAIL idle_timeout: busy_a=%0b busy_b=%0b expected both 0", busy_a, busy_b);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [SW-1:0] snap;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    snap = {busy_a, done_a, rd_en_a, if_a.out_valid, rd_addr_a, if_a.out_data,
            if_a.out_idx, if_a.out_vec_last, if_a.out_last};
    n_checks++;
    if (snap !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got %h expected 0", snap);
    end
    snap = {busy_b, done_b, rd_en_b, if_b.out_valid, rd_addr_b, if_b.out_data,
            if_b.out_idx, if_b.out_vec_last, if_b.out_last};
    n_checks++;
    if (snap !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got %h expected 0", snap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic(input string tag);
    sel = 1'b0;
    run(5'd0, 6'd8, 0, 0, 1'b0, 60);
    build_exp(0, 8);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_tuple[%0d]: got %h expected %h", tag, i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (first_valid_rel != 2 + LA) begin
      n_fail++;
      $display("FAIL %s_first_valid: got T+%0d expected T+%0d", tag, first_valid_rel, 2 + LA);
    end
    n_checks++;
    if (last_hs_rel != 1 + LA + 8) begin
      n_fail++;
      $display("FAIL %s_last_hs: got T+%0d expected T+%0d", tag, last_hs_rel, 1 + LA + 8);
    end
    n_checks++;
    if (done_rel != 2 + LA + 8 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s_done: got T+%0d (x%0d) expected T+%0d (x1)", tag, done_rel, done_cnt, 2 + LA + 8);
    end
    n_checks++;
    if (busy_cnt != 2 + LA + 8) begin
      n_fail++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", tag, busy_cnt, 2 + LA + 8);
    end
    n_checks++;
    if (addr_q.size() != 8 || addr_q[0] !== 5'd0) begin
      n_fail++;
      $display("FAIL %s_first_read: got %0d reads expected 8 starting at 0", tag, addr_q.size());
    end
  endtask

  task automatic test_wrap();
    sel = 1'b0;
    run(5'd30, 6'd4, 0, 0, 1'b0, 60);
    build_exp(30, 4);
    n_checks++;
    if (addr_q.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_reads: got %0d expected 4", addr_q.size());
    end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      n_checks++;
      if (addr_q[i] !== AW'((30 + i) % 32)) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, addr_q[i], (30 + i) % 32);
      end
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_tuple[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    sel = 1'b0;
    run(5'd7, 6'd0, 0, 0, 1'b0, 20);
    n_checks++;
    if (done_rel != 1 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_done: got T+%0d (x%0d) expected T+1 (x1)", done_rel, done_cnt);
    end
    n_checks++;
    if (addr_q.size() != 0 || first_valid_rel != -1) begin
      n_fail++;
      $display("FAIL zero_activity: got %0d reads, first valid %0d expected 0, -1", addr_q.size(), first_valid_rel);
    end
    n_checks++;
    if (busy_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_busy: got %0d cycles expected 1", busy_cnt);
    end
    // start together with abort in IDLE must not launch a run
    @(negedge clk);
    start = 1'b1; abort = 1'b1; base = 5'd3; len = 6'd4;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    n_checks++;
    if (busy_a || busy_b || done_a || done_b) begin
      n_fail++;
      $display("FAIL start_with_abort: got busy=%0b%0b done=%0b%0b expected 0", busy_a, busy_b, done_a, done_b);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignored_start();
    sel = 1'b0;
    run(5'd5, 6'd10, 2, 0, 1'b1, 200);
    build_exp(5, 10);
    n_checks++;
    if (addr_q.size() != 10 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL ign_start_reads: got %0d reads %0d dones expected 10, 1", addr_q.size(), done_cnt);
    end
    for (int i = 0; i < 10 && i < addr_q.size(); i++) begin
      n_checks++;
      if (addr_q[i] !== AW'(5 + i)) begin
        n_fail++;
        $display("FAIL ign_start_addr[%0d]: got %0d expected %0d", i, addr_q[i], 5 + i);
      end
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL ign_start_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ign_start_tuple[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b1;
    run(5'd4, 6'd12, 1, 0, 1'b0, 300);
    build_exp(4, 12);
    n_checks++;
    if (obs_q.size() != exp_q.size() || done_cnt != 1) begin
      n_fail++;
      $display("FAIL bp_count: got %0d tuples %0d dones expected %0d, 1", obs_q.size(), done_cnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_tuple[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_bad);
    end
    n_checks++;
    if (max_out > LB + 2) begin
      n_fail++;
      $display("FAIL bp_credit: got %0d outstanding expected <= %0d", max_out, LB + 2);
    end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    sel = 1'b0;
    run(5'd3, 6'd16, 0, 6, 1'b0, 100);
    build_exp(3, 16);
    n_checks++;
    if (obs_q.size() != 6 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_count: got %0d tuples %0d dones expected 6, 0", obs_q.size(), done_cnt);
    end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort_tuple[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (post_abort_bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles after abort expected 0", post_abort_bad);
    end
    run(5'd9, 6'd5, 0, 0, 1'b0, 60);
    build_exp(9, 5);
    n_checks++;
    if (obs_q.size() != exp_q.size() || done_cnt != 1) begin
      n_fail++;
      $display("FAIL abort_fresh_count: got %0d tuples %0d dones expected %0d, 1", obs_q.size(), done_cnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort_fresh_tuple[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [SW-1:0] snap;
    @(negedge clk);
    start = 1'b1; base = 5'd0; len = 6'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      snap = {busy_a, done_a, rd_en_a, if_a.out_valid, rd_addr_a, if_a.out_data,
              if_a.out_idx, if_a.out_vec_last, if_a.out_last};
      n_checks++;
      if (snap !== '0) begin
        n_fail++;
        $display("FAIL midrst_outputs[%0d]: got %h expected 0", k, snap);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic("after_rst");
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    logic [AW:0] n;
    int lat;
    for (int it = 0; it < 8; it++) begin
      sel = it[0];
      lat = sel ? LB : LA;
      b = AW'($urandom);
      n = (it == 7) ? 6'd32 : (AW+1)'($urandom_range(1, 32));
      run(b, n, 2, 0, 1'b0, 400);
      build_exp(int'(b), int'(n));
      n_checks++;
      if (obs_q.size() != exp_q.size() || done_cnt != 1) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d tuples %0d dones expected %0d, 1", it, obs_q.size(), done_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_tuple[%0d]: got %h expected %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (stall_bad != 0 || max_out > lat + 2) begin
        n_fail++;
        $display("FAIL rand%0d_flow: got unstable=%0d outstanding=%0d expected 0, <=%0d", it, stall_bad, max_out, lat + 2);
      end
    end
    sel = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic("basic");
    test_wrap();
    test_zero_len();
    test_ignored_start();
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dp_vec_streamer.md
# dp_vec_streamer

Parametrised multi-channel operand streamer for the dot-product datapath. On a start command it reads a programmable-length run of consecutive addresses from NUM_CH synchronous operand memories in lock-step. It absorbs the memories' fixed read latency and presents each element tuple on a valid/ready stream with vector-boundary and end-of-stream markers. It replaces the fixed-length, latency-blind memory reader: no backpressure loss, arbitrary base and length, and abort support.

## Interface
- DATA_WIDTH, 8, bits per element per channel
- ADDR_WIDTH, 5, memory address width
- NUM_CH, 2, number of operand memories read in parallel (≥1)
- VECTOR_WIDTH, 4, elements per vector group (≥1); drives out_vec_last
- RD_LATENCY, 1, fixed memory read latency in cycles (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  start command; accepted only in IDLE
- base_addr  in  ADDR_WIDTH  first address; sampled on accepted start
- length  in  ADDR_WIDTH+1  element count (0..2^ADDR_WIDTH); sampled on accepted start
- abort  in  1  synchronous cancel of the current run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at normal completion
- rd_en  out  1  read strobe, shared by all channels
- rd_addr  out  ADDR_WIDTH  read address, shared by all channels
- rd_data  in  NUM_CH*DATA_WIDTH  memory read data; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]; valid RD_LATENCY cycles after rd_en
- out_valid  out  1  element tuple available
- out_ready  in  1  downstream accept
- out_data  out  NUM_CH*DATA_WIDTH  element tuple, same channel packing as rd_data
- out_idx  out  ADDR_WIDTH+1  index of current element, 0..length-1
- out_vec_last  out  1  element closes a VECTOR_WIDTH group, or is the final element
- out_last  out  1  final element of the run

## Operation
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_idx=0, out_vec_last=0, out_last=0. FSM is in IDLE; FIFO and in-flight tracker are empty.
- FSM states:
  - IDLE: start=1 latches base_addr and length. length=0 → DONE; otherwise → RUN.
  - RUN: issues reads. After the length-th read is issued → DRAIN.
  - DRAIN: waits until every element has been handshaken → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - start outside IDLE is ignored.
- Issue rule: rd_en=1 in RUN only when in_flight + fifo_count < FIFO_DEPTH.
  - FIFO_DEPTH = RD_LATENCY+2.
  - in_flight and fifo_count are registered values.
  - This guarantees no returning data is ever dropped.
- Addressing: the i-th read uses rd_addr = (base_addr + i) mod 2^ADDR_WIDTH. Wrap past the top address is legal and silent.
- Return path:
  - An RD_LATENCY-deep valid shift register tracks issued reads.
  - rd_data is written into the FIFO in the cycle the matching shift-register bit emerges.
- Output:
  - out_* is driven from the FIFO head.
  - Pop on out_valid & out_ready.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Markers, evaluated on out_idx:
  - out_last = (out_idx == length-1).
  - out_vec_last = out_last | (out_idx mod VECTOR_WIDTH == VECTOR_WIDTH-1).
  - out_idx increments per pop.
- Abort, in any non-IDLE state:
  - Next cycle: FSM is in IDLE, busy=0, rd_en=0, FIFO flushed, shift register cleared (late rd_data discarded), out_valid=0.
  - No done pulse.
  - abort in IDLE has no effect. abort and start in the same IDLE cycle: start is ignored.
- Reset asserted mid-run returns all state to reset values immediately. No done pulse.

## Timing
- Start accepted at the edge ending cycle T. busy=1 from T+1 up to and including the DONE cycle.
- First rd_en in cycle T+1, with rd_addr=base_addr.
- Read issued in cycle C: data sampled at the end of cycle C+RD_LATENCY; out_valid earliest in cycle C+RD_LATENCY+1.
- First out_valid: T+2+RD_LATENCY.
- Throughput: with out_ready held 1, one tuple per cycle. A run of length N has its last handshake at T+1+RD_LATENCY+N, and done pulses in the following cycle.
- length=0: done pulses in T+1; busy=1 only in T+1; no rd_en; no out_valid.
- out_ready low: issue stalls once FIFO_DEPTH credits are consumed. rd_en resumes the cycle after a pop frees a credit.
- done and the final handshake never occur in the same cycle. A new start is accepted earliest in the cycle after done.

## Test plan
- Basic run: RD_LATENCY=1, NUM_CH=2, mem_k[a]=a+16k, base=0, length=8, out_ready=1.
  - out_data {ch1,ch0} = {16,0}..{23,7} in cycles T+3..T+10.
  - out_vec_last at idx 3 and 7; out_last at idx 7.
  - done at T+11.
- Wrap: base=30, length=4, ADDR_WIDTH=5.
  - rd_addr sequence 30, 31, 0, 1; out_idx 0..3.
  - out_vec_last only at idx 3.
- Backpressure: RD_LATENCY=3, length=12, out_ready toggled 1-0-0-1 repeatedly.
  - All 12 tuples delivered in order with none lost or duplicated.
  - data stable while stalled; in_flight+fifo_count never exceeds 5.
- Zero length and ignored start:
  - length=0 → done in T+1, no rd_en.
  - start pulsed mid-run → no change to rd_addr sequence or count.
- Abort: length=16, abort at 6th handshake.
  - Next cycle busy=0, out_valid=0, no done.
  - Stale rd_data arriving afterwards never appears on out_data.
  - A fresh start then streams from its own base_addr.
- Reset mid-run: rst_n low during RUN.
  - All outputs at reset values while low.
  - After release, a new run behaves exactly as in the basic run.
